// File: rtl/ffe_equalizer.sv
// Four-lane, five-tap feed-forward equalizer with Q1.6 weights.
// The weights are programmed over a TileLink-style register port; the data path has a one-cycle latency.
module ffe_equalizer (
  input  logic        clock,
  input  logic        reset,
  input  logic        auto_reg_in_a_valid,
  output logic        auto_reg_in_a_ready,
  input  logic [2:0]  auto_reg_in_a_bits_opcode,
  input  logic [2:0]  auto_reg_in_a_bits_param,
  input  logic [1:0]  auto_reg_in_a_bits_size,
  input  logic [2:0]  auto_reg_in_a_bits_source,
  input  logic [10:0] auto_reg_in_a_bits_address,
  input  logic [7:0]  auto_reg_in_a_bits_mask,
  input  logic [63:0] auto_reg_in_a_bits_data,
  input  logic        auto_reg_in_a_bits_corrupt,
  input  logic        auto_reg_in_d_ready,
  output logic        auto_reg_in_d_valid,
  output logic [2:0]  auto_reg_in_d_bits_opcode,
  output logic [1:0]  auto_reg_in_d_bits_size,
  output logic [2:0]  auto_reg_in_d_bits_source,
  input  logic        io_in_valid,
  input  logic [7:0]  io_in_bits_0,
  input  logic [7:0]  io_in_bits_1,
  input  logic [7:0]  io_in_bits_2,
  input  logic [7:0]  io_in_bits_3,
  output logic        io_out_valid,
  output logic [7:0]  io_out_bits_0,
  output logic [7:0]  io_out_bits_1,
  output logic [7:0]  io_out_bits_2,
  output logic [7:0]  io_out_bits_3
);

  localparam int LANES = 4;
  localparam int TAPS  = 5;
  localparam int DW    = 8;
  localparam int WFRAC = 6;
  localparam int SW    = 20;

  function automatic logic signed [SW-1:0] mul_ext(input logic signed [DW-1:0] w,
                                                   input logic signed [DW-1:0] x);
    logic signed [2*DW-1:0] p;
    p = w * x;
    mul_ext = {{(SW-2*DW){p[2*DW-1]}}, p};
  endfunction

  function automatic logic signed [DW-1:0] saturate(input logic signed [SW-1:0] acc);
    logic signed [SW-1:0] shifted;
    shifted = acc >>> WFRAC;
    if (shifted > 20'sd127) begin
      saturate = 8'sd127;
    end else if (shifted < -20'sd128) begin
      saturate = -8'sd128;
    end else begin
      saturate = shifted[DW-1:0];
    end
  endfunction

  logic signed [DW-1:0] w_r    [LANES][TAPS];
  logic signed [DW-1:0] hist_r [LANES][TAPS-1];
  logic signed [DW-1:0] out_r  [LANES];
  logic signed [DW-1:0] in_s   [LANES];
  logic signed [DW-1:0] y_s    [LANES];
  logic signed [SW-1:0] acc_s  [LANES];
  logic                 out_valid_r;

  logic       d_valid_r;
  logic [2:0] d_opcode_r;
  logic [1:0] d_size_r;
  logic [2:0] d_source_r;

  logic       a_ready_s;
  logic       a_fire_s;
  logic       wr_en_s;
  logic [1:0] wr_lane_s;
  logic       unused_s;

  assign in_s[0] = io_in_bits_0;
  assign in_s[1] = io_in_bits_1;
  assign in_s[2] = io_in_bits_2;
  assign in_s[3] = io_in_bits_3;

  assign a_ready_s = !d_valid_r || auto_reg_in_d_ready;
  assign a_fire_s  = auto_reg_in_a_valid && a_ready_s;
  assign wr_en_s   = a_fire_s
                     && ((auto_reg_in_a_bits_opcode == 3'd0) || (auto_reg_in_a_bits_opcode == 3'd1))
                     && (auto_reg_in_a_bits_address < 11'h020);
  assign wr_lane_s = auto_reg_in_a_bits_address[4:3];

  assign unused_s = ^{auto_reg_in_a_bits_param, auto_reg_in_a_bits_corrupt,
                      auto_reg_in_a_bits_address[2:0], auto_reg_in_a_bits_mask[7:5],
                      auto_reg_in_a_bits_data[63:40]};

  // FIR sum per lane; 20-bit accumulator cannot overflow for five 8x8 products
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      acc_s[l] = mul_ext(w_r[l][0], in_s[l]);
      for (int k = 1; k < TAPS; k++) begin
        acc_s[l] = acc_s[l] + mul_ext(w_r[l][k], hist_r[l][k-1]);
      end
      y_s[l] = saturate(acc_s[l]);
    end
  end

  // Weight registers: reset to identity, byte-masked writes; reserved bytes are never stored
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int l = 0; l < LANES; l++) begin
        for (int k = 0; k < TAPS; k++) begin
          w_r[l][k] <= (k == 0) ? 8'sd64 : 8'sd0;
        end
      end
    end else if (wr_en_s) begin
      for (int k = 0; k < TAPS; k++) begin
        if (auto_reg_in_a_bits_mask[k]) begin
          w_r[wr_lane_s][k] <= auto_reg_in_a_bits_data[8*k +: DW];
        end
      end
    end
  end

  // Data path: history advances and outputs update only on valid input groups
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_r <= 1'b0;
      for (int l = 0; l < LANES; l++) begin
        out_r[l] <= 8'sd0;
        for (int k = 0; k < TAPS-1; k++) begin
          hist_r[l][k] <= 8'sd0;
        end
      end
    end else begin
      out_valid_r <= io_in_valid;
      if (io_in_valid) begin
        for (int l = 0; l < LANES; l++) begin
          out_r[l]     <= y_s[l];
          hist_r[l][0] <= in_s[l];
          for (int k = 1; k < TAPS-1; k++) begin
            hist_r[l][k] <= hist_r[l][k-1];
          end
        end
      end
    end
  end

  // Response channel: one outstanding response, held until the master takes it
  always_ff @(posedge clock) begin
    if (reset) begin
      d_valid_r  <= 1'b0;
      d_opcode_r <= 3'd0;
      d_size_r   <= 2'd0;
      d_source_r <= 3'd0;
    end else if (a_fire_s) begin
      d_valid_r  <= 1'b1;
      d_opcode_r <= (auto_reg_in_a_bits_opcode == 3'd4) ? 3'd1 : 3'd0;
      d_size_r   <= auto_reg_in_a_bits_size;
      d_source_r <= auto_reg_in_a_bits_source;
    end else if (auto_reg_in_d_ready) begin
      d_valid_r  <= 1'b0;
    end
  end

  assign auto_reg_in_a_ready       = a_ready_s;
  assign auto_reg_in_d_valid       = d_valid_r;
  assign auto_reg_in_d_bits_opcode = d_opcode_r;
  assign auto_reg_in_d_bits_size   = d_size_r;
  assign auto_reg_in_d_bits_source = d_source_r;

  assign io_out_valid  = out_valid_r;
  assign io_out_bits_0 = out_r[0];
  assign io_out_bits_1 = out_r[1];
  assign io_out_bits_2 = out_r[2];
  assign io_out_bits_3 = out_r[3];

endmodule

// File: tb/tb_ffe_equalizer.sv
// Directed self-checking bench for ffe_equalizer: one task per scenario with hand-computed expectations.
module tb_ffe_equalizer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        a_valid = 1'b0;
  logic        a_ready;
  logic [2:0]  a_opcode = 3'd0;
  logic [2:0]  a_param = 3'd0;
  logic [1:0]  a_size = 2'd0;
  logic [2:0]  a_source = 3'd0;
  logic [10:0] a_address = 11'd0;
  logic [7:0]  a_mask = 8'd0;
  logic [63:0] a_data = 64'd0;
  logic        a_corrupt = 1'b0;
  logic        d_ready = 1'b1;
  logic        d_valid;
  logic [2:0]  d_opcode;
  logic [1:0]  d_size;
  logic [2:0]  d_source;
  logic        in_valid = 1'b0;
  logic [7:0]  in0 = 8'd0, in1 = 8'd0, in2 = 8'd0, in3 = 8'd0;
  logic        out_valid;
  logic [7:0]  out0, out1, out2, out3;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  ffe_equalizer dut (
    .clock(clock), .reset(reset),
    .auto_reg_in_a_valid(a_valid), .auto_reg_in_a_ready(a_ready),
    .auto_reg_in_a_bits_opcode(a_opcode), .auto_reg_in_a_bits_param(a_param),
    .auto_reg_in_a_bits_size(a_size), .auto_reg_in_a_bits_source(a_source),
    .auto_reg_in_a_bits_address(a_address), .auto_reg_in_a_bits_mask(a_mask),
    .auto_reg_in_a_bits_data(a_data), .auto_reg_in_a_bits_corrupt(a_corrupt),
    .auto_reg_in_d_ready(d_ready), .auto_reg_in_d_valid(d_valid),
    .auto_reg_in_d_bits_opcode(d_opcode), .auto_reg_in_d_bits_size(d_size),
    .auto_reg_in_d_bits_source(d_source),
    .io_in_valid(in_valid), .io_in_bits_0(in0), .io_in_bits_1(in1),
    .io_in_bits_2(in2), .io_in_bits_3(in3),
    .io_out_valid(out_valid), .io_out_bits_0(out0), .io_out_bits_1(out1),
    .io_out_bits_2(out2), .io_out_bits_3(out3)
  );

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic bus_req(input logic [2:0] op, input logic [10:0] addr, input logic [7:0] mask,
                         input logic [63:0] data, input logic [2:0] src, input logic [1:0] size);
    a_valid = 1'b1; a_opcode = op; a_address = addr; a_mask = mask;
    a_data = data; a_source = src; a_size = size;
  endtask

  task automatic bus_idle;
    a_valid = 1'b0;
  endtask

  task automatic drive_in(input logic v, input logic [7:0] x0, input logic [7:0] x1,
                          input logic [7:0] x2, input logic [7:0] x3);
    in_valid = v; in0 = x0; in1 = x1; in2 = x2; in3 = x3;
  endtask

  task automatic do_reset;
    bus_idle();
    drive_in(1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    step();
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    checks++; if ({out0, out1, out2, out3} !== 32'd0) begin errors++; $display("FAIL rst_out_bits: got %h want 0", {out0, out1, out2, out3}); end
    checks++; if (d_valid !== 1'b0) begin errors++; $display("FAIL rst_d_valid: got %b want 0", d_valid); end
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL rst_a_ready: got %b want 1", a_ready); end
    checks++; if ({d_opcode, d_size, d_source} !== 8'd0) begin errors++; $display("FAIL rst_d_bits: got %h want 0", {d_opcode, d_size, d_source}); end
    reset = 1'b0;
  endtask

  task automatic test_identity;
    drive_in(1'b1, 8'd10, 8'd236, 8'd127, 8'd128);
    step();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL id_valid: got %b want 1", out_valid); end
    checks++; if ({out0, out1, out2, out3} !== {8'd10, 8'd236, 8'd127, 8'd128})
      begin errors++; $display("FAIL id_bits: got %0d/%0d/%0d/%0d want 10/236/127/128", out0, out1, out2, out3); end
    drive_in(1'b0, 8'd55, 8'd55, 8'd55, 8'd55);
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL id_invalid: got %b want 0", out_valid); end
    checks++; if (out0 !== 8'd10) begin errors++; $display("FAIL id_hold: got %0d want 10", out0); end
  endtask

  task automatic test_write_taps;
    logic [7:0] exp0 [3];
    exp0[0] = 8'd16; exp0[1] = 8'd32; exp0[2] = 8'd40;
    do_reset();
    d_ready = 1'b1;
    bus_req(3'd0, 11'h000, 8'hFF, 64'h0000_0000_0020_4040, 3'd5, 2'd3);
    step();
    bus_idle();
    checks++; if (d_valid !== 1'b1) begin errors++; $display("FAIL wr_d_valid: got %b want 1", d_valid); end
    checks++; if ({d_opcode, d_source, d_size} !== {3'd0, 3'd5, 2'd3})
      begin errors++; $display("FAIL wr_d_bits: got op%0d src%0d sz%0d want op0 src5 sz3", d_opcode, d_source, d_size); end
    for (int i = 0; i < 3; i++) begin
      drive_in(1'b1, 8'd16, 8'd16, 8'd16, 8'd16);
      step();
      checks++; if (out0 !== exp0[i]) begin errors++; $display("FAIL taps_lane0_%0d: got %0d want %0d", i, out0, exp0[i]); end
      checks++; if ({out1, out2, out3} !== {8'd16, 8'd16, 8'd16})
        begin errors++; $display("FAIL taps_other_%0d: got %0d/%0d/%0d want 16", i, out1, out2, out3); end
    end
    checks++; if (d_valid !== 1'b0) begin errors++; $display("FAIL wr_d_clear: got %b want 0", d_valid); end
  endtask

  task automatic test_saturation;
    do_reset();
    bus_req(3'd0, 11'h010, 8'h01, 64'h0000_0000_0000_007F, 3'd0, 2'd3);
    step();
    bus_idle();
    drive_in(1'b1, 8'd0, 8'd0, 8'd127, 8'd0);
    step();
    checks++; if (out2 !== 8'd127) begin errors++; $display("FAIL sat_pos: got %0d want 127", out2); end
    drive_in(1'b1, 8'd0, 8'd0, 8'd128, 8'd0);
    step();
    checks++; if (out2 !== 8'h80) begin errors++; $display("FAIL sat_neg: got %0d want 128", out2); end
    drive_in(1'b1, 8'd0, 8'd0, 8'd246, 8'd0);
    step();
    checks++; if (out2 !== 8'hEC) begin errors++; $display("FAIL floor_neg: got %0d want 236", out2); end
    drive_in(1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
    bus_req(3'd0, 11'h020, 8'hFF, 64'd0, 3'd2, 2'd3);
    step();
    bus_req(3'd4, 11'h000, 8'hFF, 64'd0, 3'd1, 2'd3);
    step();
    bus_idle();
    checks++; if ({d_valid, d_opcode} !== {1'b1, 3'd1}) begin errors++; $display("FAIL get_ack: got v%b op%0d want v1 op1", d_valid, d_opcode); end
    drive_in(1'b1, 8'd7, 8'd0, 8'd0, 8'd0);
    step();
    checks++; if (out0 !== 8'd7) begin errors++; $display("FAIL no_effect_writes: got %0d want 7", out0); end
  endtask

  task automatic test_valid_gap;
    do_reset();
    bus_req(3'd0, 11'h008, 8'h03, 64'h0000_0000_0000_4040, 3'd0, 2'd3);
    step();
    bus_idle();
    drive_in(1'b1, 8'd0, 8'd10, 8'd0, 8'd0);
    step();
    checks++; if ({out_valid, out1} !== {1'b1, 8'd10}) begin errors++; $display("FAIL gap_first: got v%b %0d want v1 10", out_valid, out1); end
    drive_in(1'b0, 8'd0, 8'd99, 8'd0, 8'd0);
    step();
    checks++; if ({out_valid, out1} !== {1'b0, 8'd10}) begin errors++; $display("FAIL gap_hold: got v%b %0d want v0 10", out_valid, out1); end
    drive_in(1'b1, 8'd0, 8'd20, 8'd0, 8'd0);
    step();
    checks++; if ({out_valid, out1} !== {1'b1, 8'd30}) begin errors++; $display("FAIL gap_resume: got v%b %0d want v1 30", out_valid, out1); end
    drive_in(1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL gap_tail: got %b want 0", out_valid); end
  endtask

  task automatic test_backpressure;
    d_ready = 1'b0;
    bus_req(3'd0, 11'h008, 8'h00, 64'hFFFF, 3'd3, 2'd2);
    step();
    bus_req(3'd4, 11'h000, 8'h00, 64'd0, 3'd6, 2'd1);
    checks++; if ({d_valid, a_ready} !== 2'b10) begin errors++; $display("FAIL bp_stall: got v%b r%b want v1 r0", d_valid, a_ready); end
    checks++; if ({d_opcode, d_source, d_size} !== {3'd0, 3'd3, 2'd2})
      begin errors++; $display("FAIL bp_bits: got op%0d src%0d sz%0d want op0 src3 sz2", d_opcode, d_source, d_size); end
    step();
    step();
    checks++; if ({d_valid, a_ready, d_source} !== {2'b10, 3'd3}) begin errors++; $display("FAIL bp_held: got v%b r%b src%0d want v1 r0 src3", d_valid, a_ready, d_source); end
    d_ready = 1'b1;
    #1;
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got %b want 1", a_ready); end
    step();
    bus_idle();
    checks++; if ({d_valid, d_opcode, d_source} !== {1'b1, 3'd1, 3'd6}) begin errors++; $display("FAIL bp_next: got v%b op%0d src%0d want v1 op1 src6", d_valid, d_opcode, d_source); end
    step();
    checks++; if (d_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b want 0", d_valid); end
  endtask

  task automatic test_back_to_back;
    d_ready = 1'b1;
    bus_req(3'd0, 11'h018, 8'h01, 64'h20, 3'd1, 2'd3);
    drive_in(1'b1, 8'd0, 8'd0, 8'd0, 8'd10);
    step();
    checks++; if ({d_valid, d_source, out_valid, out3} !== {1'b1, 3'd1, 1'b1, 8'd10})
      begin errors++; $display("FAIL b2b_0: got v%b src%0d ov%b %0d want v1 src1 ov1 10", d_valid, d_source, out_valid, out3); end
    bus_req(3'd1, 11'h018, 8'h01, 64'h20, 3'd2, 2'd3);
    step();
    checks++; if ({d_valid, d_source, out_valid, out3} !== {1'b1, 3'd2, 1'b1, 8'd5})
      begin errors++; $display("FAIL b2b_1: got v%b src%0d ov%b %0d want v1 src2 ov1 5", d_valid, d_source, out_valid, out3); end
    bus_req(3'd4, 11'h018, 8'hFF, 64'd0, 3'd3, 2'd3);
    drive_in(1'b1, 8'd0, 8'd0, 8'd0, 8'd246);
    step();
    bus_idle();
    checks++; if ({d_valid, d_opcode, d_source, out3} !== {1'b1, 3'd1, 3'd3, 8'hFB})
      begin errors++; $display("FAIL b2b_2: got v%b op%0d src%0d %0d want v1 op1 src3 251", d_valid, d_opcode, d_source, out3); end
  endtask

  task automatic test_reset_midstream;
    d_ready = 1'b0;
    bus_req(3'd0, 11'h000, 8'h01, 64'h10, 3'd4, 2'd3);
    drive_in(1'b1, 8'd30, 8'd30, 8'd30, 8'd30);
    step();
    bus_idle();
    reset = 1'b1;
    step();
    checks++; if ({out_valid, out0, out1, out2, out3} !== 33'd0) begin errors++; $display("FAIL mid_rst_out: got v%b %h want 0", out_valid, {out0, out1, out2, out3}); end
    checks++; if (d_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_d: got %b want 0", d_valid); end
    reset = 1'b0;
    d_ready = 1'b1;
    drive_in(1'b1, 8'd20, 8'd20, 8'd20, 8'd20);
    step();
    checks++; if ({out_valid, out0, out1, out2, out3} !== {1'b1, 8'd20, 8'd20, 8'd20, 8'd20})
      begin errors++; $display("FAIL mid_identity: got v%b %0d/%0d/%0d/%0d want 20", out_valid, out0, out1, out2, out3); end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_write_taps();
    test_saturation();
    test_valid_gap();
    test_backpressure();
    test_back_to_back();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
